// File: rtl/usb_rx_decoder.sv
// USB receive front end: synchroniser, 4x bit recovery, NRZI decode,
// SYNC/EOP detection, bit unstuffing and byte assembly.
module usb_rx_decoder #(
  parameter bit FULLSPEED  = 1'b1,
  parameter int OVERSAMPLE = 4
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       linep,
  input  logic       linem,
  output logic [1:0] line_state,
  output logic       rx_active,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_eop,
  output logic       rx_error
);

  localparam logic [1:0] SE0 = 2'd0;
  localparam logic [1:0] LJ  = 2'd1;
  localparam logic [1:0] LK  = 2'd2;
  localparam logic [1:0] SE1 = 2'd3;
  localparam logic       JP  = FULLSPEED;
  localparam logic       JM  = !FULLSPEED;
  localparam logic [1:0] SPH = 2'(OVERSAMPLE / 2);

  typedef enum logic [2:0] {
    IDLE, SYNC, DATA, EOP, ERRWAIT
  } state_t;

  state_t     state;
  logic [1:0] sp, sm;
  logic [1:0] cur;
  logic [1:0] phase;
  logic [1:0] prev;
  logic [2:0] ones;
  logic [2:0] bitcnt;
  logic [7:0] shreg;
  logic [2:0] scnt;
  logic [1:0] alt;
  logic [2:0] jcnt;
  logic       se0;
  logic       smp;
  logic       dbit;
  logic [1:0] s;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      sp <= {JP, JP};
      sm <= {JM, JM};
    end else begin
      sp <= {sp[0], linep};
      sm <= {sm[0], linem};
    end
  end

  always_comb begin
    cur = SE0;
    unique case (1'b1)
      sp[1] & sm[1]:                     cur = SE1;
      ~sp[1] & ~sm[1]:                   cur = SE0;
      (sp[1] ^ sm[1]) & (sp[1] == JP):   cur = LJ;
      (sp[1] ^ sm[1]) & (sp[1] != JP):   cur = LK;
      default:                           cur = SE0;
    endcase
  end

  // Phase realigns on every edge so the sample lands mid-bit.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      line_state <= LJ;
      phase      <= 2'd0;
    end else begin
      line_state <= cur;
      phase      <= (cur != line_state) ? 2'd0 : phase + 2'd1;
    end
  end

  assign s    = line_state;
  assign smp  = (phase == SPH);
  assign dbit = (s == prev);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state     <= IDLE;
      rx_active <= 1'b0;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      rx_eop    <= 1'b0;
      rx_error  <= 1'b0;
      prev      <= LJ;
      ones      <= 3'd0;
      bitcnt    <= 3'd0;
      shreg     <= 8'h00;
      scnt      <= 3'd0;
      alt       <= 2'd0;
      jcnt      <= 3'd0;
      se0       <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_eop   <= 1'b0;
      rx_error <= 1'b0;
      if (smp) begin
        unique case (state)
          IDLE: begin
            prev   <= LJ;
            ones   <= 3'd0;
            bitcnt <= 3'd0;
            if (s == LK) begin
              state     <= SYNC;
              rx_active <= 1'b1;
              prev      <= LK;
              scnt      <= 3'd1;
              alt       <= 2'd1;
            end
          end
          SYNC: begin
            prev <= s;
            scnt <= scnt + 3'd1;
            if (s == SE0 || s == SE1) begin
              state    <= ERRWAIT;
              rx_error <= 1'b1;
              se0      <= (s == SE0);
              jcnt     <= 3'd0;
            end else if (s == LK && prev == LK && alt == 2'd3) begin
              state  <= DATA;
              ones   <= 3'd0;
              bitcnt <= 3'd0;
            end else if (scnt == 3'd7) begin
              state    <= ERRWAIT;
              rx_error <= 1'b1;
              se0      <= 1'b0;
              jcnt     <= 3'd0;
            end else if (s == prev) begin
              alt <= 2'd1;
            end else if (alt != 2'd3) begin
              alt <= alt + 2'd1;
            end
          end
          DATA: begin
            prev <= s;
            if (s == SE0) begin
              state <= EOP;
            end else if (s == SE1 || (ones == 3'd6 && dbit)) begin
              state    <= ERRWAIT;
              rx_error <= 1'b1;
              se0      <= 1'b0;
              jcnt     <= 3'd0;
            end else if (ones == 3'd6) begin
              ones <= 3'd0;
            end else begin
              shreg  <= {dbit, shreg[7:1]};
              ones   <= dbit ? ones + 3'd1 : 3'd0;
              bitcnt <= bitcnt + 3'd1;
              if (bitcnt == 3'd7) begin
                rx_data  <= {dbit, shreg[7:1]};
                rx_valid <= 1'b1;
              end
            end
          end
          EOP: begin
            if (s == LJ) begin
              state     <= IDLE;
              rx_eop    <= 1'b1;
              rx_error  <= (bitcnt != 3'd0);
              rx_active <= 1'b0;
              prev      <= LJ;
            end else if (s != SE0) begin
              state    <= ERRWAIT;
              rx_error <= 1'b1;
              se0      <= 1'b0;
              jcnt     <= 3'd0;
            end
          end
          ERRWAIT: begin
            if (s == SE0) begin
              se0  <= 1'b1;
              jcnt <= 3'd0;
            end else if (s == LJ) begin
              if (se0 || jcnt == 3'd7) begin
                state     <= IDLE;
                rx_active <= 1'b0;
                prev      <= LJ;
                se0       <= 1'b0;
                jcnt      <= 3'd0;
              end else begin
                jcnt <= jcnt + 3'd1;
              end
            end else begin
              se0  <= 1'b0;
              jcnt <= 3'd0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
